// File: rtl/top_up_arbiter_pkg.sv
// Shared definitions for the top-up arbiter: FSM state encoding and the
// default station count, credit width and revenue width.
package top_up_arbiter_pkg;

  localparam int N_ST_DEF = 4;
  localparam int W_DEF    = 10;
  localparam int RW_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/top_up_arbiter_rr_pick.sv
// Round-robin picker: scans the request vector starting at the pointer,
// wrapping from the highest station back to station 0. Purely combinational.
module rr_pick
  import top_up_arbiter_pkg::*;
#(
  parameter int N_ST = N_ST_DEF,
  parameter int PW   = 2
) (
  input  logic [N_ST-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [PW-1:0]   idx_o
);

  logic [PW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester at or
  // after the pointer is the one left in idx_o.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_ST - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_i) + k) % N_ST);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/top_up_arbiter.sv
// Cashier-path arbiter: grants one station's top-up at a time, rejects
// zero-credit or overflowing requests, loads the granted station counter
// and accumulates a saturating revenue total.
//
// Handshake: a station raises req[i] (level) with amt[i] stable and keeps it
// high until it sees ack[i] or nack[i] for one cycle; dropping req[i] before
// the check stage completes silently abandons the request, dropping it later
// does not cancel the commit.
module top_up_arbiter
  import top_up_arbiter_pkg::*;
#(
  parameter int N_ST = N_ST_DEF,
  parameter int W    = W_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ST-1:0]   req,
  input  logic [N_ST*W-1:0] amt,
  input  logic [N_ST*W-1:0] remain_i,
  output logic [N_ST-1:0]   set_o,
  output logic [W-1:0]      money_o,
  output logic [N_ST-1:0]   ack,
  output logic [N_ST-1:0]   nack,
  output logic              busy,
  output logic [RW-1:0]     revenue,
  output logic [1:0]        state_o
);

  localparam int PW = (N_ST > 1) ? $clog2(N_ST) : 1;
  localparam int SW = ((RW > W) ? RW : W) + 1;
  localparam logic [SW-1:0] REV_MAX = {{(SW - RW){1'b0}}, {RW{1'b1}}};

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     idx_q;
  logic [W-1:0]      amt_q;
  logic [N_ST-1:0]   set_q;
  logic [W-1:0]      money_q;
  logic [N_ST-1:0]   ack_q;
  logic [N_ST-1:0]   nack_q;
  logic              busy_q;
  logic [RW-1:0]     revenue_q;

  logic [W-1:0]      amt_a    [N_ST];
  logic [W-1:0]      remain_a [N_ST];
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [W:0]        sum_chk;
  logic [PW-1:0]     ptr_d;
  logic [N_ST-1:0]   idx_onehot;
  logic [SW-1:0]     rev_sum;
  logic [RW-1:0]     revenue_d;

  for (genvar g = 0; g < N_ST; g++) begin : g_unpack
    assign amt_a[g]    = amt[g*W +: W];
    assign remain_a[g] = remain_i[g*W +: W];
  end

  rr_pick #(
    .N_ST (N_ST),
    .PW   (PW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // One extra bit catches a station counter that would wrap past 2^W-1.
  assign sum_chk = {1'b0, remain_a[idx_q]} + {1'b0, amt_q};

  // Pointer moves just past the station that was answered.
  assign ptr_d = (idx_q == PW'(N_ST - 1)) ? '0 : idx_q + PW'(1);

  // Revenue add saturates instead of wrapping.
  assign rev_sum   = SW'(revenue_q) + SW'(amt_q);
  assign revenue_d = (rev_sum > REV_MAX) ? {RW{1'b1}} : rev_sum[RW-1:0];

  // Decode the latched station index into a one-hot strobe.
  always_comb begin
    idx_onehot        = '0;
    idx_onehot[idx_q] = 1'b1;
  end

  // Arbitration FSM with all strobes and status registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      amt_q     <= '0;
      set_q     <= '0;
      money_q   <= '0;
      ack_q     <= '0;
      nack_q    <= '0;
      busy_q    <= 1'b0;
      revenue_q <= '0;
    end else begin
      set_q   <= '0;
      money_q <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            idx_q   <= pick_idx;
            amt_q   <= amt_a[pick_idx];
            state_q <= ST_CHECK;
            busy_q  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (!req[idx_q]) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if ((amt_q == '0) || sum_chk[W]) begin
            nack_q  <= idx_onehot;
            ptr_q   <= ptr_d;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          set_q     <= idx_onehot;
          money_q   <= amt_q;
          ack_q     <= idx_onehot;
          revenue_q <= revenue_d;
          ptr_q     <= ptr_d;
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign set_o   = set_q;
  assign money_o = money_q;
  assign ack     = ack_q;
  assign nack    = nack_q;
  assign busy    = busy_q;
  assign revenue = revenue_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_top_up_arbiter.sv
// Bench for top_up_arbiter: directed scenarios with literal expectations,
// then randomized requesters, all cross-checked every cycle against a
// transaction-level model of the arbiter.
module tb_top_up_arbiter;

  localparam int N    = 4;
  localparam int W    = 10;
  localparam int RW   = 16;
  localparam int MAXC = (1 << W) - 1;
  localparam longint REVMAX = (64'd1 << RW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*W-1:0] amt;
  logic [N*W-1:0] remain;
  logic [N-1:0]   set_o;
  logic [W-1:0]   money_o;
  logic [N-1:0]   ack;
  logic [N-1:0]   nack;
  logic           busy;
  logic [RW-1:0]  revenue;
  logic [1:0]     state_o;

  logic [N-1:0]   req8;
  logic [N*W-1:0] amt8;
  logic [N*W-1:0] remain8;
  logic [N-1:0]   set8;
  logic [W-1:0]   money8;
  logic [N-1:0]   ack8;
  logic [N-1:0]   nack8;
  logic           busy8;
  logic [7:0]     rev8;
  logic [1:0]     state8;

  top_up_arbiter #(.N_ST(N), .W(W), .RW(RW)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .amt      (amt),
    .remain_i (remain),
    .set_o    (set_o),
    .money_o  (money_o),
    .ack      (ack),
    .nack     (nack),
    .busy     (busy),
    .revenue  (revenue),
    .state_o  (state_o)
  );

  top_up_arbiter #(.N_ST(N), .W(W), .RW(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .req      (req8),
    .amt      (amt8),
    .remain_i (remain8),
    .set_o    (set8),
    .money_o  (money8),
    .ack      (ack8),
    .nack     (nack8),
    .busy     (busy8),
    .revenue  (rev8),
    .state_o  (state8)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 50)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction is picked at edge t_start, judged at t_start+1 and, if
  // accepted, delivered at t_start+2. Expected outputs are those visible
  // after the current edge.
  int       cyc = 0;
  int       m_ptr = 0;
  bit       t_active = 1'b0;
  int       t_start, t_idx, t_amt;
  longint   exp_rev = 0;
  logic [N-1:0] exp_set, exp_ack, exp_nack;
  logic [W-1:0] exp_money;
  logic         exp_busy;

  always @(posedge clk) begin
    int rem;
    bit found;
    cyc++;
    exp_set   = '0;
    exp_ack   = '0;
    exp_nack  = '0;
    exp_money = '0;
    if (rst) begin
      m_ptr    = 0;
      t_active = 1'b0;
      exp_rev  = 0;
      exp_busy = 1'b0;
    end else begin
      if (t_active && cyc == t_start + 1) begin
        rem = int'(remain[t_idx*W +: W]);
        if (!req[t_idx]) begin
          t_active = 1'b0;
        end else if (t_amt == 0 || rem + t_amt > MAXC) begin
          exp_nack[t_idx] = 1'b1;
          m_ptr = (t_idx + 1) % N;
          t_active = 1'b0;
        end
      end else if (t_active && cyc == t_start + 2) begin
        exp_set[t_idx] = 1'b1;
        exp_ack[t_idx] = 1'b1;
        exp_money      = W'(t_amt);
        exp_rev        = (exp_rev + t_amt > REVMAX) ? REVMAX : exp_rev + t_amt;
        m_ptr          = (t_idx + 1) % N;
        t_active       = 1'b0;
      end else if (!t_active && req != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(m_ptr + k) % N]) begin
            found = 1'b1;
            t_idx = (m_ptr + k) % N;
          end
        end
        t_amt    = int'(amt[t_idx*W +: W]);
        t_start  = cyc;
        t_active = 1'b1;
      end
      exp_busy = t_active;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("set_o",   32'(set_o),   32'(exp_set));
      chk("money_o", 32'(money_o), 32'(exp_money));
      chk("ack",     32'(ack),     32'(exp_ack));
      chk("nack",    32'(nack),    32'(exp_nack));
      chk("busy",    32'(busy),    32'(exp_busy));
      chk("revenue", 32'(revenue), 32'(exp_rev));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    req8 = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic set_amt(input int i, input int v);
    amt[i*W +: W] = W'(v);
  endtask

  task automatic set_rem(input int i, input int v);
    remain[i*W +: W] = W'(v);
  endtask

  task automatic wait_ack8(input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick(1);
      if (ack8 != '0) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int ord [5];
  int tim [5];
  int n_ack;
  int r;

  initial begin
    rst = 1'b1; req = '0; amt = '0; remain = '0;
    req8 = '0; amt8 = '0; remain8 = '0;
    @(posedge clk);
    chk_en = 1'b1;

    // Reset state
    do_reset();
    chk("rst_set",   32'(set_o),   32'd0);
    chk("rst_money", 32'(money_o), 32'd0);
    chk("rst_ack",   32'(ack),     32'd0);
    chk("rst_nack",  32'(nack),    32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_rev",   32'(revenue), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);

    // Single request: strobe three edges after req is seen
    set_amt(0, 30); set_rem(0, 5); req = 4'b0001;
    tick(1); chk("single_lat1", 32'(ack), 32'd0); chk("single_busy", 32'(busy), 32'd1);
    tick(1); chk("single_lat2", 32'(ack), 32'd0);
    tick(1);
    chk("single_set",   32'(set_o),   32'h1);
    chk("single_money", 32'(money_o), 32'd30);
    chk("single_ack",   32'(ack),     32'h1);
    chk("single_rev",   32'(revenue), 32'd30);
    req = '0;
    tick(1); chk("single_money_idle", 32'(money_o), 32'd0);

    // Contention: all stations held, expect 0,1,2,3,0 at 3-cycle spacing
    do_reset();
    for (int i = 0; i < N; i++) begin set_amt(i, 1); set_rem(i, 0); end
    req = 4'b1111;
    n_ack = 0;
    for (int t = 1; t <= 30 && n_ack < 5; t++) begin
      tick(1);
      if (ack != '0) begin
        for (int j = 0; j < N; j++) if (ack[j]) ord[n_ack] = j;
        tim[n_ack] = t;
        n_ack++;
        if (n_ack == 5) req = '0;
      end
    end
    chk("rr_count", 32'(n_ack), 32'd5);
    chk("rr_first", 32'(tim[0]), 32'd3);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 32'(ord[k]), 32'(k % N));
    for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), 32'(tim[k] - tim[k-1]), 32'd3);
    tick(2);

    // Overflow boundary: 1000+30 rejected, 1000+23 accepted
    do_reset();
    set_amt(2, 30); set_rem(2, 1000); req = 4'b0100;
    tick(2);
    chk("ovf_nack", 32'(nack),  32'h4);
    chk("ovf_set",  32'(set_o), 32'h0);
    req = '0;
    tick(1); chk("ovf_noack", 32'(ack), 32'h0);
    set_amt(2, 23); req = 4'b0100;
    tick(3);
    chk("fit_ack",   32'(ack),     32'h4);
    chk("fit_money", 32'(money_o), 32'd23);
    req = '0;
    tick(1);

    // Zero amount, then abort in CHECK
    do_reset();
    set_amt(1, 0); req = 4'b0010;
    tick(2); chk("zero_nack", 32'(nack), 32'h2);
    req = '0;
    tick(1);
    set_amt(3, 5); set_rem(3, 0); req = 4'b1000;
    tick(1); chk("abort_busy_chk", 32'(busy), 32'd1);
    req = '0;
    tick(1);
    chk("abort_idle",  32'(busy),    32'd0);
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_nack",  32'(nack),    32'd0);
    tick(2); chk("abort_noack", 32'(ack), 32'd0);
    set_amt(1, 1); set_amt(3, 1); req = 4'b1010;
    tick(3); chk("abort_ptr_kept", 32'(ack), 32'h8);
    req = '0;
    tick(1);

    // Reset on the edge entering COMMIT
    do_reset();
    set_amt(2, 7); set_amt(0, 9); set_rem(0, 0); set_rem(2, 0); req = 4'b0100;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; req = 4'b0101;
    chk("rstc_set", 32'(set_o),   32'd0);
    chk("rstc_rev", 32'(revenue), 32'd0);
    tick(1); chk("rstc_noack1", 32'(ack), 32'd0);
    tick(1); chk("rstc_noack2", 32'(ack), 32'd0);
    tick(1);
    chk("rstc_ack0", 32'(ack),     32'h1);
    chk("rstc_rev9", 32'(revenue), 32'd9);
    req = '0;
    tick(1);

    // Saturation on the 8-bit revenue instance
    amt8[0 +: W] = W'(200); req8 = 4'b0001;
    wait_ack8("sat_ack1");
    req8 = '0;
    chk("sat_rev200", 32'(rev8), 32'd200);
    tick(1);
    amt8[0 +: W] = W'(100); req8 = 4'b0001;
    wait_ack8("sat_ack2");
    req8 = '0;
    chk("sat_rev255", 32'(rev8), 32'd255);
    tick(1);

    // Randomized requesters
    do_reset();
    for (int c = 0; c < 4500; c++) begin
      tick(1);
      rst = ($urandom_range(0, 1499) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i] || nack[i]) req[i] = 1'b0;
          else if ($urandom_range(0, 40) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 9);
          if (r == 0)      set_amt(i, 0);
          else if (r <= 2) set_amt(i, $urandom_range(700, 1023));
          else             set_amt(i, $urandom_range(1, 300));
          req[i] = 1'b1;
        end
        if ($urandom_range(0, 9) == 0) set_rem(i, $urandom_range(700, 1023));
        else                           set_rem(i, $urandom_range(0, 300));
      end
    end
    rst = 1'b0;
    req = '0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/top_up_arbiter.md
TOP_UP_ARBITER -- requirements
Module: top_up_arbiter

Interface
REQ-001 Parameter N_ST, default 4, number of game stations sharing the cashier path.
REQ-002 Parameter W, default 10, credit width, equal to the station counter width.
REQ-003 Parameter RW, default 16, revenue counter width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  N_ST  per-station top-up request, level, held until ack or nack.
REQ-007 amt  input  N_ST*W  per-station requested credit, station i at bits [i*W +: W].
REQ-008 remain_i  input  N_ST*W  current remaining credit of each station counter, same packing.
REQ-009 set_o  output  N_ST  one-hot, one-cycle load strobe to the granted station counter.
REQ-010 money_o  output  W  credit value driven to all station counters, valid while any set_o bit is high.
REQ-011 ack  output  N_ST  one-cycle pulse: request accepted and committed.
REQ-012 nack  output  N_ST  one-cycle pulse: request rejected.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 revenue  output  RW  total committed credit since reset.

Function
REQ-015 FSM states SHALL be IDLE, CHECK, COMMIT, all registered.
REQ-016 IDLE: with any req bit high, pick one station round-robin from the pointer, latch its index and amt, go to CHECK; otherwise stay.
REQ-017 Round-robin: search starts at the pointer and wraps N_ST-1 -> 0; the pointer becomes granted index+1 (mod N_ST) after ack or nack.
REQ-018 CHECK: req[idx] low -> abort to IDLE, no set_o, ack or nack, pointer unchanged.
REQ-019 CHECK: latched amt == 0 -> nack[idx] pulse, go to IDLE.
REQ-020 CHECK: remain_i[idx] + latched amt > 2^W-1, computed at W+1 bits -> nack[idx] pulse, go to IDLE, so a station counter never wraps.
REQ-021 CHECK: otherwise go to COMMIT.
REQ-022 COMMIT: set_o[idx]=1, money_o=latched amt, ack[idx]=1, all in the same single cycle; then go to IDLE.
REQ-023 Latency: req seen in IDLE at edge N -> set_o/ack high during the cycle after edge N+2; at most one grant per 3 cycles.
REQ-024 A req dropping after CHECK has passed SHALL NOT cancel the commit.
REQ-025 revenue SHALL add the latched amt on each commit, saturating at 2^RW-1, never wrapping.
REQ-026 set_o, ack and nack SHALL each be one-hot or zero, mutually exclusive per cycle; money_o SHALL be 0 when set_o is 0.
REQ-027 Requesters SHALL be served in round-robin order; a new req arriving mid-transaction waits for IDLE.

Reset
REQ-028 With rst high at an edge: FSM=IDLE, pointer=0, latched index/amt=0, set_o=0, money_o=0, ack=0, nack=0, busy=0, revenue=0.
REQ-029 Reset asserted in CHECK or COMMIT SHALL abandon the transaction with no strobe after that edge; requests are re-arbitrated from station 0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default N_ST, W and RW constants.
REQ-031 The round-robin picker SHALL be one sub-module, rr_pick: inputs req and pointer; outputs valid and index; combinational.
REQ-032 All outputs SHALL be driven from registers.

Verification
REQ-033 Single request: req=0001, amt0=30, remain0=5 -> set_o=0001, money_o=30, ack=0001 in the same cycle, 3 cycles after req is seen; revenue=30.
REQ-034 Contention: req=1111 held, all amt=1, remain=0 -> acks in order 0,1,2,3,0 at 3-cycle spacing.
REQ-035 Overflow: remain2=1000, amt2=30 -> nack=0100 and no set_o; with amt2=23 (sum 1023) -> ack.
REQ-036 Zero and abort: amt1=0 -> nack=0010; req3 dropped while in CHECK -> no strobe, FSM back in IDLE, pointer unchanged.
REQ-037 Reset in COMMIT-bound transaction: rst high on the edge entering COMMIT -> no set_o/ack, revenue=0, next grant goes to station 0.
REQ-038 Saturation: with RW=8, commits of 200 and 100 -> revenue=255.
